l2cache_flush_scanner: RTL and testbench

L2CACHE_FLUSH_SCANNER -- requirements
Module: L2cache_flush_scanner

---
 rtl/l2cache_flush_scanner.sv | 126 ++++++++++++
 tb/tb_l2cache_flush_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/l2cache_flush_scanner.sv
// Walks the L2 dirty table in set-major/way-minor order and writes back every dirty line.
// Each line is cleared only after its writeback request has been accepted.
module l2cache_flush_scanner #(
    parameter int addr_width = 4,
    parameter int way        = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [addr_width-1:0] dt_addr,
    output logic [1:0]            dt_way_select,
    output logic                  dt_set0,
    input  logic                  dt_dirty,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [addr_width-1:0] wb_addr,
    output logic [1:0]            wb_way
);

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, CLEAR, DONE} state_t;

    localparam logic [1:0]            WAY_LAST = 2'(way - 1);
    localparam logic [addr_width-1:0] SET_LAST = '1;

    state_t                state_q, state_d;
    logic [addr_width-1:0] set_q, set_d;
    logic [1:0]            way_q, way_d;

    logic                  last_entry;
    logic [addr_width-1:0] set_next;
    logic [1:0]            way_next;

    assign last_entry = (set_q == SET_LAST) && (way_q == WAY_LAST);

    // Only used when last_entry is false, so the set increment never wraps.
    always_comb begin
        if (way_q == WAY_LAST) begin
            way_next = 2'd0;
            set_next = set_q + 1'b1;
        end else begin
            way_next = way_q + 2'd1;
            set_next = set_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        way_d         = way_q;
        flush_busy    = 1'b1;
        flush_done    = 1'b0;
        dt_addr       = set_q;
        dt_way_select = way_q;
        dt_set0       = 1'b0;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        wb_way        = 2'd0;

        case (state_q)
            IDLE: begin
                flush_busy    = 1'b0;
                dt_addr       = '0;
                dt_way_select = 2'd0;
                if (flush_req) begin
                    state_d = SCAN;
                    set_d   = '0;
                    way_d   = 2'd0;
                end
            end
            SCAN: begin
                if (dt_dirty) begin
                    state_d = ISSUE;
                end else if (last_entry) begin
                    state_d = DONE;
                end else begin
                    set_d = set_next;
                    way_d = way_next;
                end
            end
            ISSUE: begin
                wb_valid = 1'b1;
                wb_addr  = set_q;
                wb_way   = way_q;
                if (wb_ready) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                dt_set0 = 1'b1;
                if (last_entry) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                    set_d   = set_next;
                    way_d   = way_next;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
                set_d      = '0;
                way_d      = 2'd0;
            end
            default: begin
                state_d = IDLE;
                set_d   = '0;
                way_d   = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_l2cache_flush_scanner.sv
// Randomized bench for the flush scanner: an array models the dirty table, and each scan is
// predicted from a snapshot of that table (ordered dirty list plus cycle cost per entry).
module tb_l2cache_flush_scanner;

    localparam int AW = 4;
    localparam int WY = 4;
    localparam int NE = WY * (1 << AW);

    logic          clk;
    logic          rstn;
    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;
    logic [AW-1:0] dt_addr;
    logic [1:0]    dt_way_select;
    logic          dt_set0;
    logic          dt_dirty;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [1:0]    wb_way;

    logic dirty_tbl [NE];
    int   n_checks;
    int   n_errors;

    l2cache_flush_scanner #(.addr_width(AW), .way(WY)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .dt_addr      (dt_addr),
        .dt_way_select(dt_way_select),
        .dt_set0      (dt_set0),
        .dt_dirty     (dt_dirty),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_way       (wb_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx(input logic [AW-1:0] a, input logic [1:0] w);
        return int'(a) * WY + int'(w);
    endfunction

    assign dt_dirty = dirty_tbl[idx(dt_addr, dt_way_select)];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < NE; i++) dirty_tbl[i] = 1'b0;
    endtask

    task automatic fill_table(input int density);
        for (int i = 0; i < NE; i++) dirty_tbl[i] = ($urandom_range(99) < density);
    endtask

    // Must be called at a negedge while the DUT is idle (or about to leave idle).
    task automatic run_scan(input bit start, input bit hold, input int stall_pct, input int first_stall);
        int exp_q[$];
        int nd, cyc, stalls, fstall, hs, n_set0, set0_idx, left;
        bit done, set0_pend;
        exp_q = {};
        for (int i = 0; i < NE; i++) if (dirty_tbl[i]) exp_q.push_back(i);
        nd = exp_q.size();
        cyc = 0; stalls = 0; fstall = 0; hs = 0; n_set0 = 0; set0_idx = 0;
        done = 1'b0; set0_pend = 1'b0;
        if (start) flush_req = 1'b1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!hold) flush_req = 1'b0;
            chk("busy", 32'(flush_busy), 32'd1);
            chk("set0", 32'(dt_set0), 32'(set0_pend));
            if (dt_set0) begin
                chk("set0_idx", idx(dt_addr, dt_way_select), set0_idx);
                dirty_tbl[idx(dt_addr, dt_way_select)] = 1'b0;
                n_set0++;
            end
            set0_pend = 1'b0;
            if (wb_valid) begin
                chk("wb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("wb_idx", idx(wb_addr, wb_way), exp_q[0]);
                if (hs == 0 && fstall < first_stall) begin
                    wb_ready = 1'b0;
                    fstall++;
                end else begin
                    wb_ready = ($urandom_range(99) >= stall_pct);
                end
                if (wb_ready) begin
                    hs++;
                    set0_pend = 1'b1;
                    set0_idx = idx(wb_addr, wb_way);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    stalls++;
                end
            end else begin
                wb_ready = 1'($urandom_range(1));
            end
            if (flush_done) begin
                done = 1'b1;
                chk("scan_cycles", cyc, NE + 2 * nd + stalls + 1);
            end
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("wb_count", hs, nd);
        chk("set0_count", n_set0, nd);
        left = 0;
        for (int i = 0; i < NE; i++) if (dirty_tbl[i]) left++;
        chk("table_clean", left, 0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(flush_busy), 32'd0);
            chk("idle_dt", idx(dt_addr, dt_way_select), 0);
            chk("idle_wb", 32'(wb_valid), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        n_checks = 0;
        n_errors = 0;
        rstn = 1'b0;
        flush_req = 1'b0;
        wb_ready = 1'b0;
        clear_table();

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(flush_busy), 32'd0);
        chk("rst_done", 32'(flush_done), 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        chk("rst_set0", 32'(dt_set0), 32'd0);
        rstn = 1'b1;
        idle_check(4);

        // All entries clean, single-cycle request pulse.
        run_scan(1'b1, 1'b0, 0, 0);
        idle_check(2);

        // One dirty line at set 5, way 2; writeback always ready.
        dirty_tbl[idx(4'd5, 2'd2)] = 1'b1;
        run_scan(1'b1, 1'b0, 0, 0);
        idle_check(2);

        // First and last entries dirty; first request stalls 10 cycles.
        dirty_tbl[idx(4'd0, 2'd0)] = 1'b1;
        dirty_tbl[idx(4'd15, 2'd3)] = 1'b1;
        run_scan(1'b1, 1'b0, 0, 10);
        idle_check(2);

        // Asynchronous reset while a writeback of set 3, way 1 is pending.
        dirty_tbl[idx(4'd3, 2'd1)] = 1'b1;
        flush_req = 1'b1;
        wb_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            flush_req = 1'b0;
            seen = wb_valid;
        end
        chk("issue_reached", 32'(seen), 32'd1);
        chk("issue_idx", idx(wb_addr, wb_way), idx(4'd3, 2'd1));
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", 32'(flush_busy), 32'd0);
        chk("arst_wb", 32'(wb_valid), 32'd0);
        chk("arst_wbaddr", idx(wb_addr, wb_way), 0);
        chk("arst_dt", idx(dt_addr, dt_way_select), 0);
        chk("arst_set0", 32'(dt_set0), 32'd0);
        chk("arst_keep_dirty", 32'(dirty_tbl[idx(4'd3, 2'd1)]), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        idle_check(3);
        run_scan(1'b1, 1'b0, 30, 0);
        idle_check(2);

        // Request held through DONE: exactly one idle cycle, then a fresh scan.
        fill_table(20);
        run_scan(1'b1, 1'b1, 20, 0);
        @(negedge clk);
        chk("held_idle_busy", 32'(flush_busy), 32'd0);
        dirty_tbl[$urandom_range(NE - 1)] = 1'b1;
        run_scan(1'b0, 1'b0, 20, 0);
        idle_check(2);

        for (int t = 0; t < 8; t++) begin
            fill_table($urandom_range(100));
            run_scan(1'b1, 1'b0, $urandom_range(60), $urandom_range(3));
            idle_check(1 + $urandom_range(2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
